aes_sub_bytes_iter: RTL and testbench
=====================================

Name: aes_sub_bytes_iter

Overview:
- Iterative forward SubBytes engine for the AES encrypt datapath. It is the encrypt-direction counterpart of the inverse byte substitution used on the decrypt path.
- Accepts a 128-bit AES state over a valid/ready handshake. It substitutes LANES bytes per cycle through LANES copies of the FIPS-197 forward S-box table, held internally.
- Returns the substituted state over a second valid/ready handshake.
- Sits between the AddRoundKey and ShiftRows stages of the iterative cipher round. LANES lets us trade area against latency.

Parameters:
LANES, 4, bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration-time error.

Ports:
clk        input   1    clock; all logic rising-edge
rst_n      input   1    synchronous active-low reset, sampled on rising edge of clk
in_valid   input   1    in_data is valid
in_ready   output  1    block can accept a state (high only in IDLE)
in_data    input   128  input state; byte 0 = in_data[127:120], byte 15 = in_data[7:0]
out_valid  output  1    out_data holds the completed substituted state
out_ready  input   1    downstream accepts out_data
out_data   output  128  substituted state, same byte ordering as in_data
busy       output  1    high in BUSY state

Behaviour:
- Interface decision: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge) forces the following, regardless of state. Reset mid-operation discards the in-flight state with no partial output.
  - state=IDLE, chunk counter=0, out_data=128'h0.
  - out_valid=0, busy=0, in_ready=1 from the first cycle after reset.
- K = 16/LANES (number of BUSY cycles).
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready: load in_data into the working register, counter=0, go to BUSY. Otherwise stay in IDLE.
  - BUSY: in_ready=0, busy=1. Each cycle, replace bytes [count*LANES .. count*LANES+LANES-1] of the working register with S(byte), then increment count. On the cycle where count==K-1, go to DONE. in_valid is ignored.
  - DONE: out_valid=1, in_ready=0. out_data equals the working register and is stable until the handshake. On out_valid&&out_ready: go to IDLE. out_valid drops and in_ready rises in the following cycle. There is no same-cycle re-accept.
- Latency: handshake in cycle 0 gives out_valid first high in cycle K+1 (LANES=16: cycle 2; LANES=1: cycle 17).
- Throughput: one state per K+2 cycles when out_ready is held high.
- Backpressure: out_ready low in DONE holds out_valid and out_data indefinitely.
- Substitution:
  - Combinational table lookup on registered bytes; the result is registered in the working register.
  - The S-box is the standard forward AES table, e.g. S(00)=63, S(01)=7C, S(53)=ED, S(52)=00, S(FF)=16.
  - Bytes not in the current chunk are unchanged.
- Counter: ceil(log2(K)) bits, minimum 1. It resets to 0 on accept and never wraps within one operation.
- out_data is driven from the working register and is only meaningful while out_valid=1. Its value in other states is unspecified except after reset (0).

Test Plan:
- Reset, then idle: after rst_n low for 2 cycles, then high, the bench checks in_ready=1, out_valid=0, busy=0, out_data=0.
- FIPS-197 round 1, LANES=4: in_data=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1. Required: out_data=d42711aee0bf98f1b8b45de51e415230, with out_valid first high exactly 5 cycles after the accept cycle.
- Boundary values, LANES=1 and LANES=16: in_data=00015352_FF000000_00000000_000000FF. Required: out_data=637CED00_16636363_63636363_63636316, with latency 17 and 2 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid stays 1, out_data is unchanged, and in_ready stays 0 while in_valid=1 with new data. When out_ready rises: one transfer, then in_ready=1 next cycle.
- Reset mid-BUSY (LANES=1, rst_n low at count=7): next cycle state is IDLE, out_valid=0, out_data=0. A following fresh state produces the correct full result with no residue from the aborted state.
- Back-to-back: in_valid held high with two different states and out_ready=1. Both results appear in order, and the second accept occurs exactly one cycle after the first output handshake.

Source files
------------

// File: rtl/aes_sub_bytes_iter_if.sv
// Stream bundle for the iterative SubBytes engine: one 128-bit state in,
// one substituted 128-bit state out, each on its own valid/ready pair.
interface aes_sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  // Producer/consumer side (cipher datapath around the engine).
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  // Engine side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );
endinterface

// File: rtl/aes_sub_bytes_iter.sv
// Iterative forward AES SubBytes engine. A 128-bit state is captured in a
// working register, then LANES bytes per cycle are replaced by their forward
// S-box value until all 16 bytes are done. Byte 0 is the most significant
// byte of the state.
module aes_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input logic            clk,
  input logic            rst_n,
  aes_sub_bytes_iter_if.slave bus
);

  // Number of BUSY cycles needed to cover all 16 bytes.
  localparam int K  = 16 / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
      $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 forward S-box, row = high nibble, column = low nibble.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [CW-1:0]  count_reg;
  logic [127:0]   work_reg;
  logic [127:0]   work_next;
  logic           in_ready_reg;
  logic           out_valid_reg;
  logic           busy_reg;

  logic [7:0]     work_bytes [16];
  logic [7:0]     lane_in    [LANES];
  logic [7:0]     lane_out   [LANES];
  logic [3:0]     lane_base;

  // Index of the first byte handled in the current chunk.
  assign lane_base = 4'(int'(count_reg) * LANES);

  genvar gi;
  generate
    // Byte view of the working register, byte 0 at the top.
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      assign work_bytes[gi] = work_reg[127 - 8*gi -: 8];
    end

    // One S-box copy per lane, fed from the current chunk.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_in[gi]  = work_bytes[lane_base + 4'(gi)];
      assign lane_out[gi] = sbox(lane_in[gi]);
    end

    // Each byte takes its lane result only while its chunk is active.
    for (gi = 0; gi < 16; gi++) begin : g_merge
      localparam logic [CW-1:0] CHUNK = CW'(gi / LANES);
      assign work_next[127 - 8*gi -: 8] = (count_reg == CHUNK) ? lane_out[gi % LANES]
                                                                : work_bytes[gi];
    end
  endgenerate

  // Control FSM with registered handshake outputs and the working register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      work_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            work_reg     <= bus.in_data;
            count_reg    <= '0;
            state_reg    <= BUSY;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        BUSY: begin
          work_reg <= work_next;
          if (count_reg == CW'(K - 1)) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          count_reg     <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = work_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: three instances (LANES 1, 4, 16) share one
// driver selected by sel. Expected states come from an S-box built from
// GF(2^8) inversion plus the AES affine map.
module tb_aes_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;
  int           sel;

  logic         obs_in_ready;
  logic         obs_out_valid;
  logic [127:0] obs_out_data;
  logic         obs_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];

  always #5 clk = ~clk;

  aes_sub_bytes_iter_if if1 ();
  aes_sub_bytes_iter_if if4 ();
  aes_sub_bytes_iter_if if16 ();

  assign if1.in_valid   = in_valid  && (sel == 0);
  assign if4.in_valid   = in_valid  && (sel == 1);
  assign if16.in_valid  = in_valid  && (sel == 2);
  assign if1.out_ready  = out_ready && (sel == 0);
  assign if4.out_ready  = out_ready && (sel == 1);
  assign if16.out_ready = out_ready && (sel == 2);
  assign if1.in_data    = in_data;
  assign if4.in_data    = in_data;
  assign if16.in_data   = in_data;

  aes_sub_bytes_iter #(.LANES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  aes_sub_bytes_iter #(.LANES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  aes_sub_bytes_iter #(.LANES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  always_comb begin
    obs_in_ready  = if1.in_ready;
    obs_out_valid = if1.out_valid;
    obs_out_data  = if1.out_data;
    obs_busy      = if1.busy;
    if (sel == 1) begin
      obs_in_ready  = if4.in_ready;
      obs_out_valid = if4.out_valid;
      obs_out_data  = if4.out_data;
      obs_busy      = if4.busy;
    end else if (sel == 2) begin
      obs_in_ready  = if16.in_ready;
      obs_out_valid = if16.out_valid;
      obs_out_data  = if16.out_data;
      obs_busy      = if16.busy;
    end
  end

  function automatic int lanes_of(input int s);
    return (s == 0) ? 1 : ((s == 1) ? 4 : 16);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] a;
    for (int x = 0; x < 256; x++) begin
      a   = 8'(x);
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(a, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++)
      r[127 - 8*b -: 8] = sbox_tab[s[127 - 8*b -: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the selected instance with latency and data checks.
  task automatic run_one(input logic [127:0] data, input string tag);
    int k;
    int cyc;
    logic [127:0] exp;
    k   = 16 / lanes_of(sel);
    exp = ref_sub(data);
    check({tag, "_in_ready"}, 128'(obs_in_ready), 128'(1));
    in_valid  = 1'b1;
    in_data   = data;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    while (!obs_out_valid && cyc < 64) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 128'(cyc), 128'(k + 1));
    check({tag, "_data"}, obs_out_data, exp);
    tick();
    check({tag, "_valid_drop"}, 128'(obs_out_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(obs_in_ready), 128'(1));
    $display("xfer %s lanes=%0d in=%h out=%h latency=%0d", tag, lanes_of(sel), data, exp, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] a_state;
    logic [127:0] b_state;
    logic [127:0] held;
    int           cyc;
    int           outs;
    int           accs;
    int           hs_cyc [2];
    int           acc_cyc [2];
    logic [127:0] exp_q [2];

    build_sbox();
    sel       = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Reset then idle on all instances.
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check($sformatf("rst_in_ready_s%0d", s), 128'(obs_in_ready), 128'(1));
      check($sformatf("rst_out_valid_s%0d", s), 128'(obs_out_valid), 128'(0));
      check($sformatf("rst_busy_s%0d", s), 128'(obs_busy), 128'(0));
      check($sformatf("rst_out_data_s%0d", s), obs_out_data, 128'h0);
    end

    // Known-answer vectors.
    sel = 1;
    #1;
    check("ref_fips", ref_sub(128'h193de3bea0f4e22b9ac68d2ae9f84808),
          128'hd42711aee0bf98f1b8b45de51e415230);
    run_one(128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips_l4");
    check("ref_bound", ref_sub(128'h00015352_FF000000_00000000_000000FF),
          128'h637CED00_16636363_63636363_63636316);
    sel = 0;
    #1;
    run_one(128'h00015352_FF000000_00000000_000000FF, "bound_l1");
    sel = 2;
    #1;
    run_one(128'h00015352_FF000000_00000000_000000FF, "bound_l16");

    // Random states on every lane count.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      for (int n = 0; n < 4; n++)
        run_one({$urandom, $urandom, $urandom, $urandom}, $sformatf("rand_s%0d_%0d", s, n));
    end

    // Backpressure in DONE with new data offered.
    sel = 1;
    #1;
    a_state   = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    in_data   = a_state;
    out_ready = 1'b0;
    tick();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (!obs_out_valid && cyc < 64) begin
      tick();
      cyc++;
    end
    check("bp_latency", 128'(cyc), 128'(5));
    held = ref_sub(a_state);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid_%0d", i), 128'(obs_out_valid), 128'(1));
      check($sformatf("bp_data_%0d", i), obs_out_data, held);
      check($sformatf("bp_in_ready_%0d", i), 128'(obs_in_ready), 128'(0));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 128'(obs_out_valid), 128'(0));
    check("bp_release_ready", 128'(obs_in_ready), 128'(1));
    $display("xfer backpressure lanes=4 in=%h out=%h held=10", a_state, held);

    // Reset in the middle of BUSY on the single-lane instance.
    sel = 0;
    #1;
    in_valid = 1'b1;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("midrst_busy_before", 128'(obs_busy), 128'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 128'(obs_out_valid), 128'(0));
    check("midrst_out_data", obs_out_data, 128'h0);
    check("midrst_in_ready", 128'(obs_in_ready), 128'(1));
    check("midrst_busy", 128'(obs_busy), 128'(0));
    $display("xfer midreset lanes=1 aborted at count=7");
    run_one({$urandom, $urandom, $urandom, $urandom}, "after_rst_l1");

    // Back-to-back states with in_valid held high.
    sel = 2;
    #1;
    a_state   = {$urandom, $urandom, $urandom, $urandom};
    b_state   = {$urandom, $urandom, $urandom, $urandom};
    exp_q[0]  = ref_sub(a_state);
    exp_q[1]  = ref_sub(b_state);
    in_valid  = 1'b1;
    in_data   = a_state;
    out_ready = 1'b1;
    cyc  = 0;
    outs = 0;
    accs = 0;
    hs_cyc  = '{0, 0};
    acc_cyc = '{0, 0};
    while (cyc < 40 && outs < 2) begin
      if (in_valid && obs_in_ready && accs < 2) begin
        acc_cyc[accs] = cyc;
        accs++;
      end
      if (obs_out_valid && out_ready) begin
        check($sformatf("b2b_data_%0d", outs), obs_out_data, exp_q[outs]);
        $display("xfer b2b lanes=16 idx=%0d out=%h cycle=%0d", outs, obs_out_data, cyc);
        hs_cyc[outs] = cyc;
        outs++;
      end
      tick();
      cyc++;
      if (accs == 1) in_data = b_state;
      if (accs == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_outputs", 128'(outs), 128'(2));
    check("b2b_reaccept", 128'(acc_cyc[1]), 128'(hs_cyc[0] + 1));
    check("b2b_period", 128'(hs_cyc[1] - hs_cyc[0]), 128'(3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
